saph_fpu_arb: RTL

SAPH_FPU_ARB -- requirements
Module: saph_fpu_arb

---
 rtl/saph_fpu_arb.sv | 135 +++++++++++++
 1 files changed

// File: rtl/saph_fpu_arb.sv
// Round-robin arbiter letting NREQ requesters share one fixed-latency FPU, with result steering.
// Optional build macro SAPH_FPU_ARB_STATS_EN adds issue/stall counters.
module saph_fpu_arb #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 3,
    parameter int WIDTH   = 32,
    parameter int MODE_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_trig,
    input  logic [NREQ*WIDTH-1:0]    req_lhs,
    input  logic [NREQ*WIDTH-1:0]    req_rhs,
    input  logic [NREQ*MODE_W-1:0]   req_mode,
    output logic [NREQ-1:0]          req_grant,
    output logic [NREQ-1:0]          res_valid,
    output logic [WIDTH-1:0]         res_data,
    output logic                     fpu_trig,
    output logic [WIDTH-1:0]         fpu_lhs,
    output logic [WIDTH-1:0]         fpu_rhs,
    output logic [MODE_W-1:0]        fpu_mode,
    input  logic                     fpu_ready,
    input  logic [WIDTH-1:0]         fpu_res,
    output logic                     busy
`ifdef SAPH_FPU_ARB_STATS_EN
    ,
    output logic [31:0]              stat_issued,
    output logic [31:0]              stat_stall
`endif
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W:0]   cand;
    logic             grant_found;
    logic             issue;

    logic [LATENCY-1:0] tag_vld;
    logic [IDX_W-1:0]   tag_idx [LATENCY];

    // Arbitration: first active requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NREQ)) begin
                cand = cand - (IDX_W+1)'(NREQ);
            end
            if (!grant_found && req_trig[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Reset is folded in so no grant escapes while the block is held in reset.
    assign issue    = grant_found && fpu_ready && rst_n;
    assign fpu_trig = issue;

    always_comb begin
        req_grant = '0;
        fpu_lhs   = '0;
        fpu_rhs   = '0;
        fpu_mode  = '0;
        if (issue) begin
            req_grant[grant_idx] = 1'b1;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                fpu_lhs  = req_lhs[i*WIDTH +: WIDTH];
                fpu_rhs  = req_rhs[i*WIDTH +: WIDTH];
                fpu_mode = req_mode[i*MODE_W +: MODE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (grant_idx == IDX_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Issue -> retire: tag pipeline tracks who owns each in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
        end else begin
            tag_vld[0] <= issue;
            for (int s = 1; s < LATENCY; s++) begin
                tag_vld[s] <= tag_vld[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_idx[0] <= grant_idx;
        for (int s = 1; s < LATENCY; s++) begin
            tag_idx[s] <= tag_idx[s-1];
        end
    end

    // Retire stage: steer the shared FPU result to its owner.
    always_comb begin
        res_valid = '0;
        if (tag_vld[LATENCY-1]) begin
            res_valid[tag_idx[LATENCY-1]] = 1'b1;
        end
    end

    assign res_data = fpu_res;
    assign busy     = |tag_vld;

`ifdef SAPH_FPU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (issue) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (|req_trig && !issue) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule
